// File: rtl/sha_mem_responder_if.sv
// rtl/sha_mem_responder_if.sv - engine memory bus and host req/ack port bundle for sha_mem_responder
//
// Purpose : groups the SHA-256 engine memory bus and the host preload/readback
//           port so they travel as one connection.
// Signals : mem_we, mem_addr[15:0], mem_write_data[31:0]  engine -> responder
//           mem_read_data[31:0]                           responder -> engine
//           host_req, host_we, host_addr[15:0], host_wdata[31:0]  host -> responder
//           host_rdata[31:0], host_ack                    responder -> host
// Modports: master drives requests (engine/host side), slave is the responder.
interface sha_mem_responder_if;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    logic        host_req;
    logic        host_we;
    logic [15:0] host_addr;
    logic [31:0] host_wdata;
    logic [31:0] host_rdata;
    logic        host_ack;

    modport master (
        output mem_we, mem_addr, mem_write_data,
        input  mem_read_data,
        output host_req, host_we, host_addr, host_wdata,
        input  host_rdata, host_ack
    );

    modport slave (
        input  mem_we, mem_addr, mem_write_data,
        output mem_read_data,
        input  host_req, host_we, host_addr, host_wdata,
        output host_rdata, host_ack
    );
endinterface

// File: rtl/sha_mem_responder.sv
// rtl/sha_mem_responder.sv - word-addressed memory responder with SHA-256 digest capture
//
// Purpose : DEPTH x 32-bit array shared between the SHA-256 engine (registered
//           read every cycle, write on mem_we) and a host req/ack port, selected
//           by host_mode. Engine writes into the 8-word window starting at
//           digest_base are assembled into a 256-bit digest.
// Ports   : clk, reset_n (asynchronous, active-low)
//           bus          sha_mem_responder_if.slave (engine bus + host port)
//           host_mode    1 = host owns the array, 0 = engine owns it
//           digest_base  first word address of the digest window
//           digest_clr   restart digest capture (digest data is kept)
//           digest       captured words, digest_base word in [255:224]
//           digest_valid all eight window words written since the last clear
//           oob_err      sticky out-of-range flag, cleared by err_clr
// Option  : SHA_MEM_OOB_CHECK_EN defined   -> addresses >= DEPTH are dropped
//           (writes), read as 0 and set oob_err.
//           SHA_MEM_OOB_CHECK_EN undefined -> addresses wrap modulo DEPTH
//           (DEPTH must be a power of two), oob_err is 0, err_clr unused.
module sha_mem_responder #(
    parameter int DEPTH = 512
) (
    input  logic                clk,
    input  logic                reset_n,
    sha_mem_responder_if.slave  bus,
    input  logic                host_mode,
    input  logic [15:0]         digest_base,
    input  logic                digest_clr,
    output logic [255:0]        digest,
    output logic                digest_valid,
    output logic                oob_err,
    input  logic                err_clr
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {H_IDLE, H_ACK} host_state_t;
    typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} cap_state_t;

    logic [31:0] mem [DEPTH];

    host_state_t h_state;
    cap_state_t  cap_state, cap_state_nxt;
    logic [7:0]  cap_mask, cap_mask_nxt;

    logic        eng_active;
    logic        host_go;
    logic        eng_ok;
    logic        host_ok;
    logic [16:0] win_off;
    logic        win_hit;
    logic [2:0]  slot;

    function automatic logic [AW-1:0] word_idx(input logic [15:0] a);
        if (DEPTH == 1)
            return '0;
        else
            return a[AW-1:0];
    endfunction

    assign eng_active = !host_mode;
    assign host_go    = (h_state == H_IDLE) && bus.host_req && host_mode;

`ifdef SHA_MEM_OOB_CHECK_EN
    assign eng_ok  = ({1'b0, bus.mem_addr}  < 17'(DEPTH));
    assign host_ok = ({1'b0, bus.host_addr} < 17'(DEPTH));
`else
    // Modulo addressing: every address maps onto the array.
    logic unused_bits;
    assign eng_ok      = 1'b1;
    assign host_ok     = 1'b1;
    assign unused_bits = ^{bus.host_addr, err_clr};
`endif

    // Array has no reset so preloaded data survives reset_n. The two write
    // sources are mutually exclusive through host_mode.
    always_ff @(posedge clk) begin
        if (eng_active && bus.mem_we && eng_ok)
            mem[word_idx(bus.mem_addr)] <= bus.mem_write_data;
        else if (host_go && bus.host_we && host_ok)
            mem[word_idx(bus.host_addr)] <= bus.host_wdata;
    end

    // Engine read port: reads the pre-write value on a same-address write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            bus.mem_read_data <= '0;
        else if (eng_active && eng_ok)
            bus.mem_read_data <= mem[word_idx(bus.mem_addr)];
        else
            bus.mem_read_data <= '0;
    end

    // Host FSM: access happens on the H_IDLE->H_ACK edge; H_ACK always
    // returns to H_IDLE, so a held request is served every other cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_state        <= H_IDLE;
            bus.host_ack   <= 1'b0;
            bus.host_rdata <= '0;
        end else begin
            case (h_state)
                H_IDLE: begin
                    bus.host_ack <= 1'b0;
                    if (host_go) begin
                        h_state      <= H_ACK;
                        bus.host_ack <= 1'b1;
                        if (!bus.host_we)
                            bus.host_rdata <= host_ok ? mem[word_idx(bus.host_addr)] : 32'h0;
                    end
                end
                H_ACK: begin
                    h_state      <= H_IDLE;
                    bus.host_ack <= 1'b0;
                end
                default: begin
                    h_state      <= H_IDLE;
                    bus.host_ack <= 1'b0;
                end
            endcase
        end
    end

`ifdef SHA_MEM_OOB_CHECK_EN
    logic oob_hit;
    // The engine port reads every cycle it owns the array, so a stray
    // engine address is an access even without mem_we.
    assign oob_hit = (eng_active && !eng_ok) || (host_go && !host_ok);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            oob_err <= 1'b0;
        else if (oob_hit)
            oob_err <= 1'b1;
        else if (err_clr)
            oob_err <= 1'b0;
    end
`else
    assign oob_err = 1'b0;
`endif

    // Window test in 17 bits: an address below digest_base wraps to a value
    // with bit 16 set, and digest_base+8 never wraps past 0xFFFF.
    assign win_off = {1'b0, bus.mem_addr} - {1'b0, digest_base};
    assign win_hit = eng_active && bus.mem_we && (win_off < 17'd8);
    assign slot    = win_off[2:0];

    // A clear colliding with a window write restarts capture from that
    // write; a write into a full digest also restarts with just its slot.
    always_comb begin
        cap_mask_nxt  = cap_mask;
        cap_state_nxt = cap_state;
        if (win_hit) begin
            cap_mask_nxt  = ((digest_clr || (cap_state == FULL)) ? 8'h00 : cap_mask)
                            | (8'h01 << slot);
            cap_state_nxt = (cap_mask_nxt == 8'hFF) ? FULL : PARTIAL;
        end else if (digest_clr) begin
            cap_mask_nxt  = 8'h00;
            cap_state_nxt = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_state    <= EMPTY;
            cap_mask     <= 8'h00;
            digest       <= '0;
            digest_valid <= 1'b0;
        end else begin
            cap_state    <= cap_state_nxt;
            cap_mask     <= cap_mask_nxt;
            digest_valid <= (cap_state_nxt == FULL);
            // Slot 0 sits in [255:224]: bit offset is (7-slot)*32.
            if (win_hit)
                digest[{~slot, 5'd0} +: 32] <= bus.mem_write_data;
        end
    end
endmodule

// File: tb/tb_sha_mem_responder.sv
// tb/tb_sha_mem_responder.sv - self-checking testbench for sha_mem_responder
module tb_sha_mem_responder;
    localparam int DEPTH = 512;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         host_mode = 1'b1;
    logic [15:0]  digest_base = 16'h0;
    logic         digest_clr = 1'b0;
    logic         err_clr = 1'b0;
    logic [255:0] digest;
    logic         digest_valid;
    logic         oob_err;

    sha_mem_responder_if bus();

    sha_mem_responder #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .bus          (bus),
        .host_mode    (host_mode),
        .digest_base  (digest_base),
        .digest_clr   (digest_clr),
        .digest       (digest),
        .digest_valid (digest_valid),
        .oob_err      (oob_err),
        .err_clr      (err_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } host_vec_t;

    host_vec_t   vecs[8];
    logic [31:0] exp_q[$];
    logic [31:0] dw[8];
    int          checks = 0;
    int          errors = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic check256(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %064h expected %064h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] packed_digest();
        return {dw[0], dw[1], dw[2], dw[3], dw[4], dw[5], dw[6], dw[7]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reads push their expected word at request time; it is popped on ack.
    task automatic host_access(input string name, input logic we, input logic [15:0] addr,
                               input logic [31:0] wdata, input logic [31:0] exp_rd);
        int n;
        logic [31:0] e;
        n = 0;
        if (!we) exp_q.push_back(exp_rd);
        bus.host_req   = 1'b1;
        bus.host_we    = we;
        bus.host_addr  = addr;
        bus.host_wdata = wdata;
        do begin
            tick();
            n++;
        end while (n < 16 && !bus.host_ack);
        if (!bus.host_ack) n = 999;
        bus.host_req = 1'b0;
        check32({name, " ack latency"}, 32'(n), 32'd1);
        if (!we && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (n == 1) check32({name, " rdata"}, bus.host_rdata, e);
        end
        tick();
    endtask

    task automatic eng_write(input logic [15:0] addr, input logic [31:0] data);
        bus.mem_we         = 1'b1;
        bus.mem_addr       = addr;
        bus.mem_write_data = data;
        tick();
        bus.mem_we = 1'b0;
    endtask

    initial begin
        int order_a[7];
        int order_b[8];
        logic [31:0] e;

        vecs[0] = '{1'b1, 16'h0000, 32'h61626364, 32'h0};
        vecs[1] = '{1'b0, 16'h0000, 32'h0,        32'h61626364};
        vecs[2] = '{1'b1, 16'h0005, 32'hDEADBEEF, 32'h0};
        vecs[3] = '{1'b1, 16'h01FF, 32'hCAFEF00D, 32'h0};
        vecs[4] = '{1'b0, 16'h0005, 32'h0,        32'hDEADBEEF};
        vecs[5] = '{1'b0, 16'h01FF, 32'h0,        32'hCAFEF00D};
        vecs[6] = '{1'b1, 16'h0000, 32'h01020304, 32'h0};
        vecs[7] = '{1'b0, 16'h0000, 32'h0,        32'h01020304};
        order_a = '{0, 1, 2, 4, 5, 6, 7};
        order_b = '{0, 0, 1, 3, 4, 5, 6, 7};

        bus.mem_we = 1'b0; bus.mem_addr = 16'h0; bus.mem_write_data = 32'h0;
        bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_addr = 16'h0; bus.host_wdata = 32'h0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check32("reset mem_read_data", bus.mem_read_data, 32'h0);
        check32("reset host_rdata", bus.host_rdata, 32'h0);
        check32("reset host_ack", {31'b0, bus.host_ack}, 32'h0);
        check256("reset digest", digest, 256'h0);
        check32("reset digest_valid", {31'b0, digest_valid}, 32'h0);
        check32("reset oob_err", {31'b0, oob_err}, 32'h0);
        #2 reset_n = 1'b1;
        tick();

        // Host preload and readback table
        for (int i = 0; i < 8; i++)
            host_access($sformatf("host vec %0d", i), vecs[i].we, vecs[i].addr,
                        vecs[i].wdata, vecs[i].exp_rdata);

        // Held request: served every other cycle
        exp_q.push_back(32'h01020304);
        exp_q.push_back(32'h01020304);
        bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 16'h0000;
        tick();
        check32("held req ack c1", {31'b0, bus.host_ack}, 32'd1);
        e = exp_q.pop_front();
        check32("held req rdata c1", bus.host_rdata, e);
        tick();
        check32("held req ack c2", {31'b0, bus.host_ack}, 32'd0);
        tick();
        check32("held req ack c3", {31'b0, bus.host_ack}, 32'd1);
        e = exp_q.pop_front();
        check32("held req rdata c3", bus.host_rdata, e);
        bus.host_req = 1'b0;
        tick();

        // Engine read latency and read-during-write
        host_mode = 1'b0;
        bus.mem_addr = 16'h0000;
        tick();
        check32("eng read addr0", bus.mem_read_data, 32'h01020304);
        bus.mem_addr = 16'h0005;
        #3;
        check32("eng read before edge", bus.mem_read_data, 32'h01020304);
        tick();
        check32("eng read latency", bus.mem_read_data, 32'hDEADBEEF);
        eng_write(16'h0005, 32'h12345678);
        check32("read during write old", bus.mem_read_data, 32'hDEADBEEF);
        tick();
        check32("read after write new", bus.mem_read_data, 32'h12345678);

        // Ownership: no ack while engine owns the array
        exp_q.push_back(32'h12345678);
        bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 16'h0005;
        for (int i = 0; i < 4; i++) begin
            tick();
            check32("no ack in engine mode", {31'b0, bus.host_ack}, 32'd0);
        end
        host_mode = 1'b1;
        tick();
        check32("ack after host_mode", {31'b0, bus.host_ack}, 32'd1);
        e = exp_q.pop_front();
        check32("ownership rdata", bus.host_rdata, e);
        bus.host_req = 1'b0;
        host_mode = 1'b0;
        tick();

        // Digest capture
        digest_base = 16'h0100;
        for (int i = 0; i < 8; i++) begin
            dw[i] = 32'(32'h11111111 * (i + 1));
            eng_write(16'(16'h0100 + i), dw[i]);
            check32($sformatf("digest_valid after write %0d", i),
                    {31'b0, digest_valid}, (i == 7) ? 32'd1 : 32'd0);
        end
        check256("digest full", digest,
                 256'h11111111_22222222_33333333_44444444_55555555_66666666_77777777_88888888);

        dw[3] = 32'h99999999;
        eng_write(16'h0103, dw[3]);
        check32("rewrite in FULL drops valid", {31'b0, digest_valid}, 32'd0);
        for (int k = 0; k < 7; k++) begin
            dw[order_a[k]] = 32'(32'hB0000000 + order_a[k]);
            eng_write(16'(16'h0100 + order_a[k]), dw[order_a[k]]);
            check32($sformatf("refill %0d valid", k), {31'b0, digest_valid},
                    (k == 6) ? 32'd1 : 32'd0);
        end
        check256("digest after refill", digest, packed_digest());

        // Window boundaries: just outside must not disturb capture
        eng_write(16'h00FF, 32'hEEEEEEEE);
        eng_write(16'h0108, 32'hFFFFFFFF);
        check32("outside window keeps valid", {31'b0, digest_valid}, 32'd1);
        check256("outside window keeps digest", digest, packed_digest());

        // Clear colliding with a window write
        digest_clr = 1'b1;
        dw[2] = 32'hC0C0C0C0;
        eng_write(16'h0102, dw[2]);
        digest_clr = 1'b0;
        check32("clr+write valid", {31'b0, digest_valid}, 32'd0);
        for (int k = 0; k < 8; k++) begin
            dw[order_b[k]] = 32'(32'hC1000000 + k);
            eng_write(16'(16'h0100 + order_b[k]), dw[order_b[k]]);
            check32($sformatf("after clr %0d valid", k), {31'b0, digest_valid},
                    (k == 7) ? 32'd1 : 32'd0);
        end
        check256("digest after clr refill", digest, packed_digest());

        // Clear alone keeps digest data
        digest_clr = 1'b1;
        tick();
        digest_clr = 1'b0;
        check32("clr valid", {31'b0, digest_valid}, 32'd0);
        check256("clr keeps digest", digest, packed_digest());
        for (int i = 0; i < 8; i++) begin
            dw[i] = 32'(32'hA0000000 + i);
            eng_write(16'(16'h0100 + i), dw[i]);
        end
        check32("refill valid", {31'b0, digest_valid}, 32'd1);

        // Engine writes ignored while host owns the array
        host_mode = 1'b1;
        eng_write(16'h0101, 32'h0BADF00D);
        check32("host mode mem_read_data", bus.mem_read_data, 32'h0);
        check32("host mode keeps valid", {31'b0, digest_valid}, 32'd1);
        check256("host mode keeps digest", digest, packed_digest());
        bus.mem_addr = 16'h0000;
        tick();

`ifdef SHA_MEM_OOB_CHECK_EN
        host_mode = 1'b0;
        eng_write(16'h0200, 32'hBADBAD00);
        check32("oob write sets err", {31'b0, oob_err}, 32'd1);
        tick();
        check32("oob read returns 0", bus.mem_read_data, 32'h0);
        err_clr = 1'b1;
        tick();
        check32("clr loses to oob", {31'b0, oob_err}, 32'd1);
        bus.mem_addr = 16'h0000;
        tick();
        err_clr = 1'b0;
        check32("err_clr clears", {31'b0, oob_err}, 32'd0);
        host_mode = 1'b1;
        host_access("oob write not aliased", 1'b0, 16'h0000, 32'h0, 32'h01020304);
        host_access("host oob read", 1'b0, 16'h0200, 32'h0, 32'h0);
        check32("host oob sets err", {31'b0, oob_err}, 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check32("err_clr clears host oob", {31'b0, oob_err}, 32'd0);
`else
        host_mode = 1'b0;
        eng_write(16'h0205, 32'hA5A5A5A5);
        tick();
        check32("modulo engine read", bus.mem_read_data, 32'hA5A5A5A5);
        check32("modulo no oob_err", {31'b0, oob_err}, 32'd0);
        bus.mem_addr = 16'h0000;
        host_mode = 1'b1;
        host_access("modulo host alias", 1'b0, 16'h0005, 32'h0, 32'hA5A5A5A5);
        host_access("modulo host wrap", 1'b0, 16'h03FF, 32'h0, 32'hCAFEF00D);
`endif

        // Asynchronous reset mid-operation; array contents survive
        check32("valid before reset", {31'b0, digest_valid}, 32'd1);
        #3 reset_n = 1'b0;
        #1;
        check32("async reset digest_valid", {31'b0, digest_valid}, 32'd0);
        check256("async reset digest", digest, 256'h0);
        check32("async reset host_rdata", bus.host_rdata, 32'h0);
        tick();
        #3 reset_n = 1'b1;
        tick();
        host_access("post reset read 1ff", 1'b0, 16'h01FF, 32'h0, 32'hCAFEF00D);
        host_access("post reset read 0", 1'b0, 16'h0000, 32'h0, 32'h01020304);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule

// File: doc/sha_mem_responder.md
# sha_mem_responder

Word-addressed memory responder that sits on the far side of the SHA-256 engine's memory bus: it serves the engine's registered reads and writes, and gives a testbench or host controller a req/ack port to preload message words and read back results. It also watches engine writes into a configurable 8-word digest window and assembles the 256-bit digest. When all eight words have landed, it raises `digest_valid`.

## Interface
- `DEPTH`, 512, number of 32-bit words in the array; 1..65536.
- `clk`  in  1  clock; engine's `mem_clk` is tied to this clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `mem_we`  in  1  engine write enable.
- `mem_addr`  in  16  engine word address.
- `mem_write_data`  in  32  engine write data.
- `mem_read_data`  out  32  registered read data for engine.
- `host_mode`  in  1  1 = host owns array, 0 = engine owns array.
- `host_req`  in  1  host access request, held until `host_ack`.
- `host_we`  in  1  host write (1) / read (0), stable while `host_req`.
- `host_addr`  in  16  host word address, stable while `host_req`.
- `host_wdata`  in  32  host write data.
- `host_rdata`  out  32  host read data, valid when `host_ack`.
- `host_ack`  out  1  one-cycle completion pulse.
- `digest_base`  in  16  first word address of digest window; static while engine runs.
- `digest_clr`  in  1  clears digest capture.
- `digest`  out  256  captured digest; word at `digest_base` in [255:224].
- `digest_valid`  out  1  all 8 window words written since last clear.
- `oob_err`  out  1  sticky out-of-range access flag.
- `err_clr`  in  1  clears `oob_err`.

## Operation
- Array: `DEPTH` x 32-bit, not reset (contents undefined after power-up).
- Ownership: `host_mode`=0 → engine port active every cycle; host requests wait (no ack). `host_mode`=1 → engine writes ignored, `mem_read_data` returns 0, host served.
- Engine read: every cycle, array[`mem_addr`] registered into `mem_read_data`. Engine write: when `mem_we`=1, array[`mem_addr`] ← `mem_write_data`.
- Read-during-write, same address: read returns old data.
- Host FSM states are H_IDLE and H_ACK.
  - H_IDLE → H_ACK when `host_req` && `host_mode`. The access (read or write) happens on that edge.
  - H_ACK pulses `host_ack`. It returns to H_IDLE unconditionally.
  - If `host_req` is still high in H_IDLE, it is a new access.
  - Dropping `host_mode` while in H_ACK still completes the ack.
- Out-of-range: any access with addr ≥ `DEPTH` is handled as follows.
  - Writes are dropped.
  - Reads return 0.
  - `oob_err` is set.
  - `err_clr` clears it; set wins over a simultaneous clear.
- Digest capture covers engine writes only, with addr in [`digest_base`, `digest_base`+8).
  - The window bound is computed in 17 bits; it does not wrap past 0xFFFF.
  - Each window write stores the word into `digest` slot (addr−`digest_base`) and sets that bit of an 8-bit mask.
- Capture FSM states are EMPTY (mask 0), PARTIAL and FULL.
  - EMPTY→PARTIAL on the first window write.
  - PARTIAL→FULL when the mask reaches 0xFF.
  - A window write in FULL → PARTIAL, mask = only that bit, other slots keep old data.
  - `digest_clr` → EMPTY with mask 0; `digest` is not cleared.
  - `digest_clr` and a window write in the same cycle: the clear applies first, then the write → PARTIAL.
  - Repeated writes to the same slot overwrite it and leave the mask unchanged.
- `digest_valid` = (state == FULL), registered.

## Timing
- Reset values:
  - `mem_read_data`=0, `host_rdata`=0, `host_ack`=0.
  - `digest`=0, `digest_valid`=0, `oob_err`=0.
  - Host FSM H_IDLE, capture FSM EMPTY.
- Engine read latency: 1 cycle. An address presented before edge T has its data valid after edge T.
- Engine write commits at the edge where `mem_we`=1.
- Host latency: ack and rdata appear 1 cycle after `host_req` is seen with `host_mode`=1. Maximum throughput is one access per 2 cycles.
- `digest_valid` rises the cycle after the edge that commits the 8th distinct window word.
- `oob_err` rises the cycle after the offending edge.
- Reset mid-operation: all FSMs and outputs go to reset values immediately. Array contents are preserved.

## Configuration
- `SHA_MEM_OOB_CHECK_EN` defined: out-of-range checking as above.
- Not defined:
  - Addresses are taken modulo `DEPTH` (low log2(`DEPTH`) bits; `DEPTH` must then be a power of two).
  - `oob_err` is tied to 0 and `err_clr` is ignored.

## Test plan
- Host preload and readback:
  - Stimulus: `host_mode`=1; write 0x61626364 to addr 0x0000, then read addr 0x0000.
  - Response: `host_ack` one cycle after each request, `host_rdata`=0x61626364.
- Engine read latency:
  - Stimulus: preload addr 5 = 0xDEADBEEF, `host_mode`=0, drive `mem_addr`=5 at cycle T.
  - Response: `mem_read_data`=0xDEADBEEF from T+1.
- Digest capture:
  - Stimulus: `digest_base`=0x0100; engine writes 0x11111111..0x88888888 to 0x0100..0x0107 on consecutive cycles.
  - Response: `digest_valid` rises 1 cycle after the 8th write; `digest`=0x11111111_22222222_…_88888888.
  - Follow-up: a further write to 0x0103 drops `digest_valid`.
- Clear/write collision:
  - Stimulus: in FULL, assert `digest_clr` with an engine write to 0x0102.
  - Response: PARTIAL, `digest_valid`=0, the next 7 distinct words restore `digest_valid`=1.
- Out-of-range (macro defined, `DEPTH`=512):
  - Stimulus: engine write to 0x0200, then read 0x0200.
  - Response: write dropped, `mem_read_data`=0, `oob_err`=1 until `err_clr`.
  - Stimulus: `err_clr` together with another OOB access.
  - Response: `oob_err` stays 1.
- Ownership and reset:
  - Stimulus: `host_req` while `host_mode`=0.
  - Response: no `host_ack` until `host_mode`=1.
  - Stimulus: assert `reset_n`=0 mid-capture.
  - Response: `digest_valid`=0, `digest`=0; prior array data still readable afterwards.
